prm_edge_mask_sweep: RTL and testbench

Sweep sequencer for the PRM edge-validity checker. It drives 15-bit configuration codes into a `prm_oblgc_chk*` checker (bit 0 = A … bit 14 = O) and collects the `edge_mask` results. The results are packed into 32-bit mask words and streamed out over a valid/ready interface toward roadmap memory. This block sits between the roadmap controller (start/parameters) and the mask store; the checker itself is instantiated outside it.

---
 rtl/prm_chk_pkg.sv | 27 ++
 rtl/prm_chk_result_pipe.sv | 35 +++
 rtl/prm_edge_mask_sweep.sv | 96 +++++++++
 tb/tb_prm_edge_mask_sweep.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/prm_chk_pkg.sv
// prm_chk_pkg: shared widths, sweep states and checker letter-to-bit mapping
package prm_chk_pkg;
   localparam int CODE_W = 15;
   localparam int WORD_W = 32;
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_DRAIN = 3'd2,
      S_PUSH  = 3'd3,
      S_DONE  = 3'd4
   } sweep_state_t;
   localparam int BIT_A = 0;
   localparam int BIT_B = 1;
   localparam int BIT_C = 2;
   localparam int BIT_D = 3;
   localparam int BIT_E = 4;
   localparam int BIT_F = 5;
   localparam int BIT_G = 6;
   localparam int BIT_H = 7;
   localparam int BIT_I = 8;
   localparam int BIT_J = 9;
   localparam int BIT_K = 10;
   localparam int BIT_L = 11;
   localparam int BIT_M = 12;
   localparam int BIT_N = 13;
   localparam int BIT_O = 14;
endpackage

// File: rtl/prm_chk_result_pipe.sv
// prm_chk_result_pipe: CHK_LAT-deep delay line for the issue valid bit and slot tag
module prm_chk_result_pipe #(
   parameter int CHK_LAT = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [4:0] in_slot,
   output logic       out_valid,
   output logic [4:0] out_slot
);
   if (CHK_LAT == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk & rst_n;
      assign out_valid = in_valid;
      assign out_slot  = in_slot;
   end else begin : g_pipe
      logic [CHK_LAT-1:0]      v;
      logic [CHK_LAT-1:0][4:0] s;
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) begin
            v <= '0;
            s <= '0;
         end else begin
            v[0] <= in_valid;
            s[0] <= in_slot;
            for (int i = 1; i < CHK_LAT; i++) begin
               v[i] <= v[i-1];
               s[i] <= s[i-1];
            end
         end
      assign out_valid = v[CHK_LAT-1];
      assign out_slot  = s[CHK_LAT-1];
   end
endmodule

// File: rtl/prm_edge_mask_sweep.sv
// prm_edge_mask_sweep: sweeps checker codes and packs edge_mask results into 32-bit words
module prm_edge_mask_sweep
   import prm_chk_pkg::*;
#(
   parameter int CHK_LAT = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CODE_W-1:0] code_base,
   input  logic [15:0]       code_count,
   output logic [CODE_W-1:0] chk_code,
   output logic              chk_valid,
   input  logic              chk_mask,
   output logic [WORD_W-1:0] mask_word,
   output logic              mask_valid,
   input  logic              mask_ready,
   output logic [9:0]        mask_index,
   output logic              mask_last,
   output logic [15:0]       hit_count,
   output logic              busy,
   output logic              done
);
   localparam logic [2:0] DRAIN_LAST = 3'(CHK_LAT > 0 ? CHK_LAT - 1 : 0);
   sweep_state_t state;
   logic [15:0]  rem;
   logic [4:0]   slot;
   logic [2:0]   dcnt;
   logic         cap_valid;
   logic [4:0]   cap_slot;
   logic         word_end;
   assign chk_valid  = state == S_ISSUE;
   assign mask_valid = state == S_PUSH;
   assign mask_last  = mask_valid && rem == 16'd0;
   assign busy       = state != S_IDLE;
   assign done       = state == S_DONE;
   assign word_end   = slot == 5'd31 || rem == 16'd1;
   prm_chk_result_pipe #(.CHK_LAT(CHK_LAT)) u_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (chk_valid),
      .in_slot   (slot),
      .out_valid (cap_valid),
      .out_slot  (cap_slot)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state      <= S_IDLE;
         chk_code   <= '0;
         mask_word  <= '0;
         mask_index <= '0;
         hit_count  <= '0;
         rem        <= '0;
         slot       <= '0;
         dcnt       <= '0;
      end else begin
         if (cap_valid && chk_mask) begin
            mask_word[cap_slot] <= 1'b1;
            hit_count           <= hit_count + 16'd1;
         end
         case (state)
            S_IDLE: if (start) begin
               chk_code   <= code_count == 16'd0 ? chk_code : code_base;
               rem        <= code_count;
               hit_count  <= '0;
               mask_word  <= '0;
               mask_index <= '0;
               slot       <= '0;
               state      <= code_count == 16'd0 ? S_DONE : S_ISSUE;
            end
            S_ISSUE: begin
               rem  <= rem - 16'd1;
               slot <= slot + 5'd1;
               dcnt <= '0;
               // chk_code holds the last issued code until the next word starts
               if (!word_end) chk_code <= chk_code + CODE_W'(1);
               else state <= CHK_LAT == 0 ? S_PUSH : S_DRAIN;
            end
            S_DRAIN: begin
               dcnt <= dcnt + 3'd1;
               if (dcnt == DRAIN_LAST) state <= S_PUSH;
            end
            S_PUSH: if (mask_ready) begin
               if (rem == 16'd0) state <= S_DONE;
               else begin
                  state      <= S_ISSUE;
                  mask_word  <= '0;
                  mask_index <= mask_index + 10'd1;
                  slot       <= '0;
                  chk_code   <= chk_code + CODE_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
endmodule

// File: tb/tb_prm_edge_mask_sweep.sv
// tb_prm_edge_mask_sweep: directed checks of the sweep sequencer at CHK_LAT 0 and 3
module tb_prm_edge_mask_sweep;
   logic clk = 1'b0;
   logic rst_n, start, mask_ready, stub_mode;
   logic [14:0] code_base;
   logic [15:0] code_count;
   logic [14:0] c0, c3;
   logic cv0, cv3, mv0, mv3, last0, last3, busy0, busy3, done0, done3, m0, m3;
   logic [31:0] w0, w3;
   logic [9:0] idx0, idx3;
   logic [15:0] hit0, hit3;
   logic [2:0] d3 = '0;
   int total = 0, bad = 0;
   logic [31:0] wq0[$], wq3[$];
   logic lq0[$], lq3[$];
   logic [9:0] xq0[$], xq3[$];
   logic [15:0] hq0[$], hq3[$];
   logic [14:0] codes0[$];
   int push0, push3, dn0, dn3, busy_n;
   bit timed_out;

   always #5 clk = ~clk;

   // checker stubs: zero-latency for dut0, three-cycle pipeline for dut3
   assign m0 = stub_mode | c0[0];
   always_ff @(posedge clk) d3 <= {d3[1:0], stub_mode | c3[0]};
   assign m3 = d3[2];

   prm_edge_mask_sweep #(.CHK_LAT(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .code_base(code_base), .code_count(code_count),
      .chk_code(c0), .chk_valid(cv0), .chk_mask(m0), .mask_word(w0), .mask_valid(mv0),
      .mask_ready(mask_ready), .mask_index(idx0), .mask_last(last0), .hit_count(hit0),
      .busy(busy0), .done(done0));
   prm_edge_mask_sweep #(.CHK_LAT(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start), .code_base(code_base), .code_count(code_count),
      .chk_code(c3), .chk_valid(cv3), .chk_mask(m3), .mask_word(w3), .mask_valid(mv3),
      .mask_ready(mask_ready), .mask_index(idx3), .mask_last(last3), .hit_count(hit3),
      .busy(busy3), .done(done3));

   task automatic pulse_start(input logic [14:0] base, input logic [15:0] cnt, input logic mode);
      @(negedge clk);
      code_base = base; code_count = cnt; stub_mode = mode; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // observation only: records issues, accepted words and timing, n=0 is the cycle after start
   task automatic collect(input int budget, input bit poke);
      bit d0 = 0, dd3 = 0;
      wq0.delete(); wq3.delete(); lq0.delete(); lq3.delete(); xq0.delete(); xq3.delete();
      hq0.delete(); hq3.delete(); codes0.delete();
      push0 = -1; push3 = -1; dn0 = -1; dn3 = -1; busy_n = 0;
      for (int n = 0; n < budget && !(d0 && dd3); n++) begin
         start = 1'b0;
         if (cv0) codes0.push_back(c0);
         if (busy0) busy_n++;
         if (mv0 && push0 < 0) push0 = n;
         if (mv3 && push3 < 0) push3 = n;
         if (mv0 && mask_ready) begin wq0.push_back(w0); lq0.push_back(last0); xq0.push_back(idx0); hq0.push_back(hit0); end
         if (mv3 && mask_ready) begin wq3.push_back(w3); lq3.push_back(last3); xq3.push_back(idx3); hq3.push_back(hit3); end
         if (done0 && !d0) begin d0 = 1; dn0 = n; end
         if (done3 && !dd3) begin dd3 = 1; dn3 = n; end
         if (poke && n == 5) begin code_base = 15'h0555; code_count = 16'd0; start = 1'b1; end
         if (poke && mv0 && push0 == n) start = 1'b1;
         @(negedge clk);
      end
      start = 1'b0;
      timed_out = !(d0 && dd3);
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start = 1'b0; mask_ready = 1'b1; stub_mode = 1'b0; code_base = '0; code_count = '0;
      repeat (2) @(negedge clk);
      total++; if ({c0, cv0, w0, mv0, idx0, last0, hit0, busy0, done0} !== '0) begin bad++; $display("FAIL reset_dut0 got=%h exp=0", {c0, cv0, w0, mv0, idx0, last0, hit0, busy0, done0}); end
      total++; if ({c3, cv3, w3, mv3, idx3, last3, hit3, busy3, done3} !== '0) begin bad++; $display("FAIL reset_dut3 got=%h exp=0", {c3, cv3, w3, mv3, idx3, last3, hit3, busy3, done3}); end
      rst_n = 1'b1;
      pulse_start(15'h0000, 16'd32, 1'b1);
      repeat (10) @(negedge clk);
      total++; if (hit0 === 16'd0) begin bad++; $display("FAIL midrun_hits_before_reset got=%0d exp=nonzero", hit0); end
      #2 rst_n = 1'b0;
      #1;
      total++; if ({c0, cv0, w0, mv0, idx0, last0, hit0, busy0, done0} !== '0) begin bad++; $display("FAIL midreset_dut0 got=%h exp=0", {c0, cv0, w0, mv0, idx0, last0, hit0, busy0, done0}); end
      total++; if ({c3, cv3, w3, mv3, idx3, last3, hit3, busy3, done3} !== '0) begin bad++; $display("FAIL midreset_dut3 got=%h exp=0", {c3, cv3, w3, mv3, idx3, last3, hit3, busy3, done3}); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_full_word;
      pulse_start(15'h0000, 16'd32, 1'b0);
      total++; if (cv0 !== 1'b1 || busy0 !== 1'b1 || c0 !== 15'h0000) begin bad++; $display("FAIL fw_first_issue got=%b%b/%h exp=11/0000", cv0, busy0, c0); end
      collect(200, 1'b0);
      total++; if (timed_out) begin bad++; $display("FAIL fw_timeout got=1 exp=0"); end
      total++; if (codes0.size() !== 32) begin bad++; $display("FAIL fw_issue_count got=%0d exp=32", codes0.size()); end
      for (int i = 0; i < 32; i++) begin
         total++; if (codes0[i] !== 15'(i)) begin bad++; $display("FAIL fw_code[%0d] got=%h exp=%h", i, codes0[i], 15'(i)); end
      end
      total++; if (wq0.size() !== 1 || wq0[0] !== 32'hAAAAAAAA || xq0[0] !== 10'd0 || lq0[0] !== 1'b1 || hq0[0] !== 16'd16) begin bad++; $display("FAIL fw_dut0_word got=%h/%0d/%b/%0d exp=aaaaaaaa/0/1/16", wq0[0], xq0[0], lq0[0], hq0[0]); end
      total++; if (wq3.size() !== 1 || wq3[0] !== 32'hAAAAAAAA || xq3[0] !== 10'd0 || lq3[0] !== 1'b1 || hq3[0] !== 16'd16) begin bad++; $display("FAIL fw_dut3_word got=%h/%0d/%b/%0d exp=aaaaaaaa/0/1/16", wq3[0], xq3[0], lq3[0], hq3[0]); end
      total++; if (push0 !== 32 || dn0 !== 33) begin bad++; $display("FAIL fw_dut0_timing got=%0d/%0d exp=32/33", push0, dn0); end
      total++; if (push3 !== 35 || dn3 !== 36) begin bad++; $display("FAIL fw_dut3_timing got=%0d/%0d exp=35/36", push3, dn3); end
      total++; if (busy_n !== 34) begin bad++; $display("FAIL fw_busy_cycles got=%0d exp=34", busy_n); end
      total++; if (done0 !== 1'b0 || busy3 !== 1'b0 || c0 !== 15'h001F) begin bad++; $display("FAIL fw_after got=%b%b/%h exp=00/001f", done0, busy3, c0); end
   endtask

   task automatic test_wrap_partial;
      pulse_start(15'h7FF0, 16'd40, 1'b1);
      collect(300, 1'b0);
      total++; if (timed_out) begin bad++; $display("FAIL wrap_timeout got=1 exp=0"); end
      total++; if (codes0.size() !== 40) begin bad++; $display("FAIL wrap_issue_count got=%0d exp=40", codes0.size()); end
      for (int i = 0; i < 40; i++) begin
         total++; if (codes0[i] !== 15'(15'h7FF0 + i)) begin bad++; $display("FAIL wrap_code[%0d] got=%h exp=%h", i, codes0[i], 15'(15'h7FF0 + i)); end
      end
      total++; if (wq0.size() !== 2 || wq0[0] !== 32'hFFFFFFFF || lq0[0] !== 1'b0 || xq0[0] !== 10'd0 || hq0[0] !== 16'd32) begin bad++; $display("FAIL wrap_word0 got=%h/%b/%0d/%0d exp=ffffffff/0/0/32", wq0[0], lq0[0], xq0[0], hq0[0]); end
      total++; if (wq0[1] !== 32'h000000FF || lq0[1] !== 1'b1 || xq0[1] !== 10'd1 || hq0[1] !== 16'd40) begin bad++; $display("FAIL wrap_word1 got=%h/%b/%0d/%0d exp=000000ff/1/1/40", wq0[1], lq0[1], xq0[1], hq0[1]); end
      total++; if (wq3.size() !== 2 || wq3[1] !== 32'h000000FF || lq3[1] !== 1'b1 || hq3[1] !== 16'd40) begin bad++; $display("FAIL wrap_dut3_word1 got=%h/%b/%0d exp=000000ff/1/40", wq3[1], lq3[1], hq3[1]); end
      total++; if (push0 !== 32 || dn0 !== 42) begin bad++; $display("FAIL wrap_timing got=%0d/%0d exp=32/42", push0, dn0); end
   endtask

   task automatic test_empty;
      pulse_start(15'h1234, 16'd0, 1'b0);
      total++; if (done0 !== 1'b1 || busy0 !== 1'b1 || done3 !== 1'b1) begin bad++; $display("FAIL empty_done got=%b%b%b exp=111", done0, busy0, done3); end
      collect(50, 1'b0);
      total++; if (push0 !== -1 || push3 !== -1 || dn0 !== 0) begin bad++; $display("FAIL empty_no_push got=%0d/%0d/%0d exp=-1/-1/0", push0, push3, dn0); end
      total++; if (busy_n !== 1 || busy0 !== 1'b0 || done0 !== 1'b0) begin bad++; $display("FAIL empty_busy got=%0d/%b%b exp=1/00", busy_n, busy0, done0); end
      total++; if (c0 !== 15'h0017) begin bad++; $display("FAIL empty_code_hold got=%h exp=0017", c0); end
   endtask

   task automatic test_back_to_back;
      int n;
      logic [31:0] held;
      pulse_start(15'h0100, 16'd64, 1'b0);
      for (n = 0; n < 100 && !mv0; n++) @(negedge clk);
      total++; if (!mv0) begin bad++; $display("FAIL bp_wait_push got=0 exp=1"); end
      mask_ready = 1'b0;
      held = w0;
      total++; if (held !== 32'hAAAAAAAA || idx0 !== 10'd0 || last0 !== 1'b0) begin bad++; $display("FAIL bp_word0 got=%h/%0d/%b exp=aaaaaaaa/0/0", held, idx0, last0); end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         total++; if (mv0 !== 1'b1 || w0 !== held || cv0 !== 1'b0 || c0 !== 15'h011F) begin bad++; $display("FAIL bp_hold[%0d] got=%b/%h/%b/%h exp=1/%h/0/011f", i, mv0, w0, cv0, c0, held); end
      end
      mask_ready = 1'b1;
      @(negedge clk);
      total++; if (mv0 !== 1'b0 || cv0 !== 1'b1 || c0 !== 15'h0120 || w0 !== 32'h0) begin bad++; $display("FAIL bp_resume got=%b/%b/%h/%h exp=0/1/0120/0", mv0, cv0, c0, w0); end
      for (n = 0; n < 100 && !(mv0 && mask_ready); n++) @(negedge clk);
      total++; if (w0 !== 32'hAAAAAAAA || idx0 !== 10'd1 || last0 !== 1'b1 || hit0 !== 16'd32) begin bad++; $display("FAIL bp_word1 got=%h/%0d/%b/%0d exp=aaaaaaaa/1/1/32", w0, idx0, last0, hit0); end
      for (n = 0; n < 200 && (busy0 || busy3); n++) @(negedge clk);
      total++; if (busy0 || busy3) begin bad++; $display("FAIL bp_idle_timeout got=busy exp=idle"); end
   endtask

   task automatic test_start_while_busy;
      pulse_start(15'h0200, 16'd33, 1'b1);
      collect(300, 1'b1);
      total++; if (timed_out) begin bad++; $display("FAIL swb_timeout got=1 exp=0"); end
      total++; if (codes0.size() !== 33 || codes0[0] !== 15'h0200 || codes0[32] !== 15'h0220) begin bad++; $display("FAIL swb_codes got=%0d/%h/%h exp=33/0200/0220", codes0.size(), codes0[0], codes0[32]); end
      total++; if (wq0.size() !== 2 || wq0[0] !== 32'hFFFFFFFF || wq0[1] !== 32'h00000001 || hq0[1] !== 16'd33) begin bad++; $display("FAIL swb_words got=%h/%h/%0d exp=ffffffff/00000001/33", wq0[0], wq0[1], hq0[1]); end
      total++; if (push0 !== 32 || dn0 !== 35 || wq3.size() !== 2) begin bad++; $display("FAIL swb_timing got=%0d/%0d/%0d exp=32/35/2", push0, dn0, wq3.size()); end
      repeat (3) @(negedge clk);
      total++; if (busy0 !== 1'b0 || busy3 !== 1'b0) begin bad++; $display("FAIL swb_restart got=%b%b exp=00", busy0, busy3); end
   endtask

   initial begin
      test_reset;
      test_full_word;
      test_wrap_partial;
      test_empty;
      test_back_to_back;
      test_start_while_busy;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
